// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle for alu_mc. The slave modport is the ALU
// side; the master modport is whoever issues operations and consumes results.
interface alu_mc_if #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
);
    // A transfer happens on a rising edge where valid and ready are both high;
    // the sender holds its payload stable from raising valid until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ALU_In1;
    logic [WIDTH-1:0] ALU_In2;
    logic [3:0]       Opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             N_Flag;
    logic             Z_Flag;
    logic             V_Flag;
    logic             Illegal_Op;

    modport slave (
        input  in_valid, ALU_In1, ALU_In2, Opcode, out_ready,
        output in_ready, out_valid, ALU_Out, N_Flag, Z_Flag, V_Flag, Illegal_Op
    );

    modport master (
        output in_valid, ALU_In1, ALU_In2, Opcode, out_ready,
        input  in_ready, out_valid, ALU_Out, N_Flag, Z_Flag, V_Flag, Illegal_Op
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: saturating add/sub, xor, lane-wise saturating add, and
// shifts/rotates that move one bit position per EXEC cycle.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_mc_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int AW = $clog2(WIDTH);
    localparam int NL = WIDTH / LANE;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] out_q;
    logic [3:0]       op_q;
    logic [AW-1:0]    cnt_q;
    logic             n_q, z_q, v_q, ill_q;

    logic             accept;
    logic             is_shift;
    logic             start_exec;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] res;
    logic             res_ov;
    logic             upd_nzv;
    logic             upd_z;
    logic             illegal;
    logic [WIDTH-1:0] step;
    logic             last_step;

    // Returns {overflow, saturated result} for a +/- b in two's complement.
    function automatic logic [WIDTH:0] sat_addsub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sub
    );
        logic [WIDTH-1:0] bb;
        logic [WIDTH-1:0] s;
        logic             ov;
        bb = sub ? ~b : b;
        s  = a + bb + {{(WIDTH-1){1'b0}}, sub};
        ov = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        if (ov) begin
            s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return {ov, s};
    endfunction

    // Independent saturating adds per LANE-bit slice; no carry crosses lanes.
    function automatic logic [WIDTH-1:0] paddsb(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        logic [LANE-1:0]  la, lb, ls;
        logic             ov;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            la = a[i*LANE +: LANE];
            lb = b[i*LANE +: LANE];
            ls = la + lb;
            ov = (la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]);
            if (ov) begin
                ls = la[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
            end
            r[i*LANE +: LANE] = ls;
        end
        return r;
    endfunction

    assign accept     = bus.in_valid && bus.in_ready;
    assign amt        = bus.ALU_In2[AW-1:0];
    assign is_shift   = (bus.Opcode == OP_SLL) || (bus.Opcode == OP_SRA) ||
                        (bus.Opcode == OP_ROR);
    assign start_exec = accept && is_shift && (amt != '0);
    assign last_step  = (cnt_q == AW'(1));

    // Single-cycle result, used for every opcode except a non-zero shift.
    always_comb begin
        res     = '0;
        res_ov  = 1'b0;
        upd_nzv = 1'b0;
        upd_z   = 1'b0;
        illegal = 1'b0;
        case (bus.Opcode)
            OP_ADD: begin
                {res_ov, res} = sat_addsub(bus.ALU_In1, bus.ALU_In2, 1'b0);
                upd_nzv       = 1'b1;
            end
            OP_SUB: begin
                {res_ov, res} = sat_addsub(bus.ALU_In1, bus.ALU_In2, 1'b1);
                upd_nzv       = 1'b1;
            end
            OP_XOR: begin
                res   = bus.ALU_In1 ^ bus.ALU_In2;
                upd_z = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                res   = bus.ALU_In1;
                upd_z = 1'b1;
            end
            OP_PADDSB: begin
                res = paddsb(bus.ALU_In1, bus.ALU_In2);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        step = work_q;
        case (op_q)
            OP_SLL:  step = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OP_ROR:  step = {work_q[0], work_q[WIDTH-1:1]};
            default: step = work_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = start_exec ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result and flags change only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            work_q <= '0;
            out_q  <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.Opcode;
                        if (start_exec) begin
                            work_q <= bus.ALU_In1;
                            cnt_q  <= amt;
                        end else begin
                            out_q <= res;
                            ill_q <= illegal;
                            if (upd_nzv) begin
                                n_q <= res[WIDTH-1];
                                z_q <= (res == '0);
                                v_q <= res_ov;
                            end
                            if (upd_z) begin
                                z_q <= (res == '0);
                            end
                        end
                    end
                end
                EXEC: begin
                    work_q <= step;
                    cnt_q  <= cnt_q - AW'(1);
                    if (last_step) begin
                        out_q <= step;
                        z_q   <= (step == '0);
                        ill_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE) && rst;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.ALU_Out    = out_q;
    assign bus.N_Flag     = n_q;
    assign bus.Z_Flag     = z_q;
    assign bus.V_Flag     = v_q;
    assign bus.Illegal_Op = ill_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=16, LANE=4) with hand-computed results,
// latencies and flags.
module tb_alu_mc;
    localparam int W = 16;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;

    alu_mc_if #(.WIDTH(W), .LANE(4)) bus ();

    alu_mc #(.WIDTH(W), .LANE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns at a falling edge; operands are scrambled right after
    // the accepting edge so a result built from live inputs would show up.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input logic [W-1:0] eo,
                         input logic n, input logic z, input logic v, input logic ill);
        int cnt;
        exp_q.push_back(eo);
        check({tag, " in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.Opcode   = op;
        bus.ALU_In1  = a;
        bus.ALU_In2  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.Opcode   = OP_XOR;
        bus.ALU_In1  = 16'hDEAD;
        bus.ALU_In2  = 16'h0000;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.out_valid && cnt < 40);
        check({tag, " latency"}, cnt, lat);
        check({tag, " out"}, bus.ALU_Out, exp_q.pop_front());
        check({tag, " N"}, bus.N_Flag, n);
        check({tag, " Z"}, bus.Z_Flag, z);
        check({tag, " V"}, bus.V_Flag, v);
        check({tag, " ill"}, bus.Illegal_Op, ill);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Opcode    = '0;
        bus.ALU_In1   = '0;
        bus.ALU_In2   = '0;

        repeat (3) @(negedge clk);
        check("rst in_ready", bus.in_ready, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out", bus.ALU_Out, 0);
        check("rst nzv", {bus.N_Flag, bus.Z_Flag, bus.V_Flag}, 0);
        check("rst ill", bus.Illegal_Op, 0);
        check("rst state", dbg_state, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel in_ready", bus.in_ready, 1);

        do_op("add_pos_sat", OP_ADD, 16'h7000, 16'h2000, 1, 16'h7FFF, 0, 0, 1, 0);
        do_op("sub_zero",    OP_SUB, 16'h0005, 16'h0005, 1, 16'h0000, 0, 1, 0, 0);
        do_op("add_set_v",   OP_ADD, 16'h7000, 16'h2000, 1, 16'h7FFF, 0, 0, 1, 0);
        do_op("sra3",        OP_SRA, 16'h8000, 16'h0003, 4, 16'hF000, 0, 0, 1, 0);
        do_op("ror4",        OP_ROR, 16'h0001, 16'h0004, 5, 16'h1000, 0, 0, 1, 0);
        do_op("sll1",        OP_SLL, 16'h8001, 16'h0001, 2, 16'h0002, 0, 0, 1, 0);
        do_op("sll0",        OP_SLL, 16'h8001, 16'h0000, 1, 16'h8001, 0, 0, 1, 0);
        do_op("add_neg_sat", OP_ADD, 16'h8000, 16'hFFFF, 1, 16'h8000, 1, 0, 1, 0);
        do_op("sub_pos_sat", OP_SUB, 16'h7FFF, 16'hFFFF, 1, 16'h7FFF, 0, 0, 1, 0);
        do_op("add_plain",   OP_ADD, 16'h1234, 16'h0001, 1, 16'h1235, 0, 0, 0, 0);
        do_op("sra_to_zero", OP_SRA, 16'h0008, 16'h0004, 5, 16'h0000, 0, 1, 0, 0);
        do_op("padd_pos",    OP_PADDSB, 16'h7777, 16'h1111, 1, 16'h7777, 0, 1, 0, 0);
        do_op("padd_neg",    OP_PADDSB, 16'h8888, 16'hFFFF, 1, 16'h8888, 0, 1, 0, 0);
        do_op("padd_plain",  OP_PADDSB, 16'h1234, 16'h4321, 1, 16'h5555, 0, 1, 0, 0);
        do_op("xor",         OP_XOR, 16'hA5A5, 16'hFFFF, 1, 16'h5A5A, 0, 0, 0, 0);
        do_op("xor_zero",    OP_XOR, 16'h3C3C, 16'h3C3C, 1, 16'h0000, 0, 1, 0, 0);
        do_op("illegal_c",   4'b1100, 16'h1234, 16'h0001, 1, 16'h0000, 0, 1, 0, 1);
        do_op("illegal_3",   4'b0011, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 0, 1, 0, 1);
        do_op("add_clr_ill", OP_ADD, 16'h7000, 16'h2000, 1, 16'h7FFF, 0, 0, 1, 0);

        // Backpressure: result held for three cycles with in_valid pushing a new op.
        bus.in_valid = 1'b1;
        bus.Opcode   = OP_XOR;
        bus.ALU_In1  = 16'h00FF;
        bus.ALU_In2  = 16'h0F0F;
        @(posedge clk);
        #1;
        bus.Opcode  = OP_ADD;
        bus.ALU_In1 = 16'h1111;
        bus.ALU_In2 = 16'h1111;
        @(negedge clk);
        check("bp valid", bus.out_valid, 1);
        check("bp out", bus.ALU_Out, 16'h0FF0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp hold out", bus.ALU_Out, 16'h0FF0);
            check("bp hold valid", bus.out_valid, 1);
            check("bp hold in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp after valid", bus.out_valid, 0);
        check("bp after in_ready", bus.in_ready, 1);
        check("bp after out", bus.ALU_Out, 16'h0FF0);
        check("bp flags", {bus.N_Flag, bus.Z_Flag, bus.V_Flag}, 3'b001);

        // Reset during the third EXEC cycle of ROR by 7.
        bus.in_valid = 1'b1;
        bus.Opcode   = OP_ROR;
        bus.ALU_In1  = 16'h0081;
        bus.ALU_In2  = 16'h0007;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ror7 exec", dbg_state, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid rst state", dbg_state, 0);
        check("mid rst valid", bus.out_valid, 0);
        check("mid rst out", bus.ALU_Out, 0);
        check("mid rst nzv", {bus.N_Flag, bus.Z_Flag, bus.V_Flag}, 0);
        check("mid rst ill", bus.Illegal_Op, 0);
        check("mid rst in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post rst in_ready", bus.in_ready, 1);
        check("post rst valid", bus.out_valid, 0);

        do_op("post_rst_add", OP_ADD, 16'h0001, 16'h0001, 1, 16'h0002, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
